// File: rtl/visualizador_periodo_pkg.sv
// Shared types and constants for the period display: FSM states, BCD width and 7-segment codes.
package paquete_visualizador;

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        CONVIERTE = 2'd1,
        ACTUALIZA = 2'd2
    } estado_t;

    localparam int ANCHO_BCD = 16;

    localparam logic [6:0] SEG_BLANCO = 7'h7F;

    // Active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] TABLA_SEG [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] codigo_segmentos(input logic [3:0] digito);
        if (digito <= 4'd9) begin
            return TABLA_SEG[digito];
        end
        return SEG_BLANCO;
    endfunction

endpackage

// File: rtl/visualizador_periodo_conversor.sv
// Iterative shift-add-3 binary to BCD converter, one bit per clock; listo flags the final iteration.
module conversor_bin_bcd
    import paquete_visualizador::*;
#(
    parameter int ANCHO_DATO = 12
) (
    input  logic                  reloj_placa,
    input  logic                  reinicio_n,
    input  logic                  inicio,
    input  logic [ANCHO_DATO-1:0] dato,
    output logic                  listo,
    output logic [ANCHO_BCD-1:0]  bcd
);

    localparam int ANCHO_CNT = $clog2(ANCHO_DATO + 1);
    localparam logic [ANCHO_CNT-1:0] ULTIMA = ANCHO_CNT'(ANCHO_DATO - 1);

    logic [ANCHO_BCD-1:0]  r_bcd;
    logic [ANCHO_DATO-1:0] r_bin;
    logic [ANCHO_CNT-1:0]  r_iter;
    logic                  r_activo;
    logic [ANCHO_BCD-1:0]  w_bcd_aj;

    always_comb begin
        w_bcd_aj = r_bcd;
        for (int i = 0; i < ANCHO_BCD / 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_aj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Listo is combinational so the FSM leaves CONVIERTE on the same edge as the last shift.
    assign listo = r_activo && (r_iter == ULTIMA);
    assign bcd   = r_bcd;

    always_ff @(posedge reloj_placa) begin
        if (!reinicio_n) begin
            r_bcd    <= '0;
            r_bin    <= '0;
            r_iter   <= '0;
            r_activo <= 1'b0;
        end else if (inicio) begin
            r_bcd    <= '0;
            r_bin    <= dato;
            r_iter   <= '0;
            r_activo <= 1'b1;
        end else if (r_activo) begin
            {r_bcd, r_bin} <= {w_bcd_aj, r_bin} << 1;
            r_iter         <= r_iter + 1'b1;
            if (listo) begin
                r_activo <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/visualizador_periodo.sv
// Period display top: capture FSM with one-deep pending register, BCD conversion and 4-digit scan.
// Define BLANQUEO_CEROS_EN to blank leading zero digits.
//
// state     | meaning
// ESPERA    | idle, display holds last value
// CONVIERTE | shift-add-3 iterations running
// ACTUALIZA | copy BCD result into displayed digits
module visualizador_periodo
    import paquete_visualizador::*;
#(
    parameter int ANCHO_DATO   = 12,
    parameter int DIV_REFRESCO = 50000
) (
    input  logic                  reloj_placa,
    input  logic                  reinicio_n,
    input  logic [ANCHO_DATO-1:0] valor_periodo,
    input  logic                  valor_valido,
    output logic                  ocupado,
    output logic [3:0]            anodos,
    output logic [6:0]            segmentos
);

    localparam int ANCHO_REF = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam logic [ANCHO_REF-1:0] REF_MAX = ANCHO_REF'(DIV_REFRESCO - 1);

    estado_t               r_estado, w_estado_sig;
    logic                  w_carga, w_actualiza, w_listo;
    logic [ANCHO_DATO-1:0] w_dato_carga;
    logic [ANCHO_BCD-1:0]  w_bcd, r_digitos;
    logic                  r_pend_lleno;
    logic [ANCHO_DATO-1:0] r_pend_dato;
    logic                  r_ocupado;
    logic [ANCHO_REF-1:0]  r_cuenta;
    logic [1:0]            r_indice;
    logic [3:0]            r_anodos;
    logic [6:0]            r_segmentos;
    logic                  w_fin_barrido;
    logic [3:0]            w_digito;
    logic [3:0]            w_blanco;
    logic [6:0]            w_codigo;

    conversor_bin_bcd #(.ANCHO_DATO(ANCHO_DATO)) u_conversor (
        .reloj_placa (reloj_placa),
        .reinicio_n  (reinicio_n),
        .inicio      (w_carga),
        .dato        (w_dato_carga),
        .listo       (w_listo),
        .bcd         (w_bcd)
    );

    always_ff @(posedge reloj_placa) begin
        if (!reinicio_n) begin
            r_estado <= ESPERA;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            ESPERA:    if (valor_valido) w_estado_sig = CONVIERTE;
            CONVIERTE: if (w_listo) w_estado_sig = ACTUALIZA;
            ACTUALIZA: w_estado_sig = (valor_valido || r_pend_lleno) ? CONVIERTE : ESPERA;
            default:   w_estado_sig = ESPERA;
        endcase
    end

    // A fresh strobe in ACTUALIZA beats the pending value.
    always_comb begin
        w_carga      = 1'b0;
        w_actualiza  = 1'b0;
        w_dato_carga = valor_periodo;
        case (r_estado)
            ESPERA: w_carga = valor_valido;
            ACTUALIZA: begin
                w_actualiza = 1'b1;
                w_carga     = valor_valido || r_pend_lleno;
                if (!valor_valido) begin
                    w_dato_carga = r_pend_dato;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge reloj_placa) begin
        if (!reinicio_n) begin
            r_ocupado    <= 1'b0;
            r_pend_lleno <= 1'b0;
            r_pend_dato  <= '0;
            r_digitos    <= '0;
        end else begin
            r_ocupado <= (w_estado_sig != ESPERA);
            if (r_estado == CONVIERTE && valor_valido) begin
                r_pend_lleno <= 1'b1;
                r_pend_dato  <= valor_periodo;
            end else if (w_actualiza) begin
                r_pend_lleno <= 1'b0;
            end
            if (w_actualiza) begin
                r_digitos <= w_bcd;
            end
        end
    end

    assign w_fin_barrido = (r_cuenta == REF_MAX);
    assign w_digito      = r_digitos[{r_indice, 2'b00} +: 4];

`ifdef BLANQUEO_CEROS_EN
    always_comb begin
        w_blanco    = 4'b0000;
        w_blanco[3] = (r_digitos[15:12] == 4'd0);
        w_blanco[2] = w_blanco[3] && (r_digitos[11:8] == 4'd0);
        w_blanco[1] = w_blanco[2] && (r_digitos[7:4] == 4'd0);
    end
`else
    assign w_blanco = 4'b0000;
`endif

    assign w_codigo = w_blanco[r_indice] ? SEG_BLANCO : codigo_segmentos(w_digito);

    // The digit at the current index is latched on the wrap, then the index moves on.
    always_ff @(posedge reloj_placa) begin
        if (!reinicio_n) begin
            r_cuenta    <= '0;
            r_indice    <= 2'd0;
            r_anodos    <= 4'b1111;
            r_segmentos <= SEG_BLANCO;
        end else begin
            r_cuenta <= w_fin_barrido ? '0 : r_cuenta + 1'b1;
            if (w_fin_barrido) begin
                r_indice    <= r_indice + 2'd1;
                r_anodos    <= ~(4'b0001 << r_indice);
                r_segmentos <= w_codigo;
            end
        end
    end

    assign ocupado   = r_ocupado;
    assign anodos    = r_anodos;
    assign segmentos = r_segmentos;

endmodule

// File: tb/tb_visualizador_periodo.sv
// Self-checking bench for visualizador_periodo with DIV_REFRESCO=4; honours BLANQUEO_CEROS_EN.
module tb_visualizador_periodo;

    localparam int DIV = 4;

    logic        reloj_placa = 1'b0;
    logic        reinicio_n = 1'b0;
    logic [11:0] valor_periodo = '0;
    logic        valor_valido = 1'b0;
    logic        ocupado;
    logic [3:0]  anodos;
    logic [6:0]  segmentos;

    int checks = 0;
    int failures = 0;

    logic [6:0] tabla_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    visualizador_periodo #(.ANCHO_DATO(12), .DIV_REFRESCO(DIV)) dut (
        .reloj_placa   (reloj_placa),
        .reinicio_n    (reinicio_n),
        .valor_periodo (valor_periodo),
        .valor_valido  (valor_valido),
        .ocupado       (ocupado),
        .anodos        (anodos),
        .segmentos     (segmentos)
    );

    always #5 reloj_placa = ~reloj_placa;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge reloj_placa);
        #1;
    endtask

    // Reference: decimal digit of v at position idx, blank if it is a leading zero.
    function automatic int seg_esperado(input int v, input int idx);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
`ifdef BLANQUEO_CEROS_EN
        if (idx > 0 && v < p) return 'h7F;
`endif
        return int'(tabla_ref[(v / p) % 10]);
    endfunction

    function automatic int indice_de(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic strobe(input int v);
        valor_periodo = 12'(v);
        valor_valido  = 1'b1;
        tick();
        valor_valido  = 1'b0;
    endtask

    task automatic strobe_busy(input int v);
        int n = 0;
        strobe(v);
        while (ocupado && n < 100) begin
            n++;
            tick();
        end
        check_val($sformatf("busy_len_%0d", v), n, 13);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ocupado && n < 300) begin
            tick();
            n++;
        end
        check_val("idle_timeout", int'(n < 300), 1);
    endtask

    task automatic check_display(input int v);
        int seen = 0;
        int idx;
        repeat (DIV) tick();
        for (int c = 0; c < 5 * DIV; c++) begin
            tick();
            idx = indice_de(anodos);
            if (idx >= 0) begin
                seen |= (1 << idx);
                check_val($sformatf("seg_v%0d_d%0d", v, idx), int'(segmentos), seg_esperado(v, idx));
            end
        end
        check_val($sformatf("scan_all_v%0d", v), seen, 15);
    endtask

    initial begin
        int v, last, nstr, idx, highs;
        bit lowed;

        // Reset held three cycles
        repeat (3) begin
            tick();
            check_val("rst_anodos", int'(anodos), 'hF);
            check_val("rst_seg", int'(segmentos), 'h7F);
            check_val("rst_ocupado", int'(ocupado), 0);
        end
        reinicio_n = 1'b1;
        repeat (DIV - 1) begin
            tick();
            check_val("pre_first_lit", int'(anodos), 'hF);
        end
        tick();
        check_val("first_lit_anodos", int'(anodos), 'hE);
        check_val("first_lit_seg", int'(segmentos), 'h40);

        foreach (tabla_ref[i]) begin end
        strobe_busy(1234);
        repeat (DIV) tick();
        check_display(1234);
        strobe_busy(4095);
        check_display(4095);
        strobe_busy(7);
        check_display(7);
        strobe_busy(0);
        check_display(0);

        // 100, then 7 three cycles later, then 9 five cycles after that
        highs = 0;
        lowed = 0;
        for (int c = 0; c < 46; c++) begin
            valor_valido  = (c == 0 || c == 3 || c == 8);
            valor_periodo = (c == 0) ? 12'd100 : (c == 3) ? 12'd7 : 12'd9;
            tick();
            valor_valido = 1'b0;
            if (!ocupado) lowed = 1;
            else if (!lowed) highs++;
            idx = indice_de(anodos);
            if (idx >= 0 && c >= 17 && c <= 26)
                check_val($sformatf("pend_v100_c%0d", c), int'(segmentos), seg_esperado(100, idx));
            if (idx >= 0 && c >= 31)
                check_val($sformatf("pend_v9_c%0d", c), int'(segmentos), seg_esperado(9, idx));
        end
        check_val("pend_busy_len", highs, 26);
        check_display(9);

        // Random single values
        for (int r = 0; r < 6; r++) begin
            v = $urandom_range(0, 4095);
            strobe_busy(v);
            check_display(v);
        end

        // Random bursts: the last strobe always ends up displayed
        for (int r = 0; r < 5; r++) begin
            nstr = $urandom_range(2, 4);
            last = 0;
            for (int s = 0; s < nstr; s++) begin
                last = $urandom_range(0, 4095);
                strobe(last);
                repeat ($urandom_range(0, 11)) tick();
            end
            wait_idle();
            check_display(last);
        end

        // Reset in the middle of converting 2048
        strobe(2048);
        repeat (5) tick();
        reinicio_n = 1'b0;
        tick();
        check_val("midrst_ocupado", int'(ocupado), 0);
        check_val("midrst_anodos", int'(anodos), 'hF);
        check_val("midrst_seg", int'(segmentos), 'h7F);
        repeat (2) tick();
        reinicio_n = 1'b1;
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c < DIV - 1) check_val("midrst_dark", int'(anodos), 'hF);
            if (ocupado) highs++;
        end
        check_val("midrst_no_resume", highs, 0);
        check_display(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
